reg_access_init: RTL and testbench
==================================

Name: reg_access_init

Overview:
- Initiator side of the register-access byte protocol.
- Turns a single host request (read or write, 7-bit address, 8-bit data) into the command byte stream consumed by the responder-side FSM/address decoder.
- For reads, waits for the returned data byte and hands it back to the host.
- Sits between a host/sequencer and the serial-link FSM; one transaction in flight at a time.

Parameters:
- ADDR_W, 7, register address width; command byte is {wr, addr}.
- DATA_W, 8, data byte width.
- TIMEOUT, 255, max cycles to wait for a read response before flagging an error (1..65535).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  host request valid.
- req_ready  output  1  block can accept a request.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  target register address.
- req_wdata  input  DATA_W  write data (ignored for reads).
- rsp_valid  output  1  one-cycle transaction-complete pulse.
- rsp_rdata  output  DATA_W  read data (0 for writes/errors).
- rsp_err  output  1  read timed out; valid with rsp_valid.
- tx_data  output  8  byte to link FSM.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  link FSM accepts byte.
- rx_data  input  8  byte returned from responder.
- rx_valid  input  1  rx_data valid, single-cycle strobe (responder's data_received).
- busy  output  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock domain; rst sampled on rising clk edge.
- Reset values: all outputs 0 except req_ready = 1. State = IDLE, counter = 0, latched request = 0.
- Reset mid-operation: aborts immediately, drops tx_valid the next cycle, no rsp_valid is produced for the aborted request.
- States: IDLE, SEND_CMD, SEND_DATA, WAIT_RESP, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch wr/addr/wdata, go to SEND_CMD.
  - req_ready is 0 in every other state.
- SEND_CMD:
  - tx_valid = 1, tx_data = {wr, addr[6:0]}; bit 7 is the write flag.
  - Held stable until tx_ready.
  - On handshake: wr=1 goes to SEND_DATA; wr=0 goes to WAIT_RESP with counter cleared.
- SEND_DATA:
  - tx_valid = 1, tx_data = wdata, held until tx_ready.
  - On handshake: rdata_reg = 0, err_reg = 0, go to DONE.
- WAIT_RESP:
  - tx_valid = 0; counter increments every cycle.
  - rx_valid=1: rdata_reg = rx_data, err_reg = 0, go to DONE.
  - Else counter == TIMEOUT-1: rdata_reg = 0, err_reg = 1, go to DONE.
  - rx_valid and timeout in the same cycle: data wins, err = 0.
- DONE: rsp_valid = 1 for exactly one cycle, rsp_rdata/rsp_err driven from registers, then IDLE.
- rsp_rdata and rsp_err hold their last values until the next DONE.
- rx_valid outside WAIT_RESP is ignored (no state change, no capture).
- tx_ready while tx_valid = 0 has no effect.
- Counter width: $clog2(TIMEOUT+1); no wrap, since the state exits at TIMEOUT-1.
- Latency with tx_ready tied high (accept = cycle 0):
  - Write: command byte on cycle 1, data byte on cycle 2, rsp_valid on cycle 3.
  - Read: command byte on cycle 1, WAIT_RESP from cycle 2; rx_valid on cycle k gives rsp_valid on cycle k+1.
- Next request can be accepted the cycle after DONE (IDLE).
- All outputs are registered or decoded from the state register; no combinational path from req_* or rx_* to outputs.

Decomposition:
- Shared package reg_link_pkg:
  - state enum (IDLE, SEND_CMD, SEND_DATA, WAIT_RESP, DONE);
  - CMD_WR_BIT = 7;
  - ADDR_W / DATA_W constants;
  - a function building the command byte {wr, addr}.
- The responder-side address decoder imports the same package.
- One natural sub-module: resp_timer, a loadable clear/enable counter with a terminal-count flag, TIMEOUT parameter.

Test Plan:
- Write, tx_ready=1: req wr=1 addr=7'h15 wdata=8'hA5.
  - tx bytes 8'h95 then 8'hA5 on cycles 1,2.
  - rsp_valid on cycle 3 with rdata=0, err=0.
- Read with response: req wr=0 addr=7'h03.
  - tx byte 8'h03.
  - rx_valid with 8'h5C four cycles later gives rsp_valid next cycle, rdata=8'h5C, err=0.
- Read timeout, TIMEOUT=8: no rx_valid.
  - rsp_valid exactly 8 cycles after WAIT_RESP entry, err=1, rdata=0.
  - Then rx_valid at the exact terminal cycle in a second run: err=0, data captured.
- Backpressure: tx_ready low for 5 cycles during both SEND_CMD and SEND_DATA.
  - tx_data/tx_valid stable throughout, req_ready=0, no byte duplicated.
  - rsp_valid one cycle after the final handshake.
- Reset and stray strobes:
  - rst asserted in WAIT_RESP: next cycle busy=0, req_ready=1, tx_valid=0, no rsp_valid.
  - Spurious rx_valid in IDLE: ignored.
  - New request immediately after reset completes normally.

Source files
------------

// File: rtl/reg_link_pkg.sv
// Shared definitions for the register-access byte link (initiator and responder sides).
package reg_link_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CMD_WR_BIT = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_CMD  = 3'd1,
        SEND_DATA = 3'd2,
        WAIT_RESP = 3'd3,
        DONE      = 3'd4
    } state_e;

    // Command byte: write flag in the MSB, register address below it.
    function automatic logic [7:0] cmd_byte(input logic wr, input logic [ADDR_W-1:0] addr);
        logic [7:0] b;
        b             = 8'(addr);
        b[CMD_WR_BIT] = wr;
        return b;
    endfunction

endpackage

// File: rtl/reg_access_init_if.sv
// Host request/response and link byte signals of the register-access initiator.
interface reg_access_init_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;

    // Drives requests, consumes responses, and plays the link FSM.
    modport master (
        output req_valid, req_wr, req_addr, req_wdata, tx_ready, rx_data, rx_valid,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, tx_data, tx_valid
    );

    // The initiator block itself.
    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, tx_ready, rx_data, rx_valid,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, tx_data, tx_valid
    );
endinterface

// File: rtl/reg_access_init_resp_timer.sv
// Read-response timer: clearable, enabled up-counter flagging the last allowed wait cycle.
module resp_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == CNT_W'(TIMEOUT - 1));

    // Count while enabled; hold at terminal count so the value never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/reg_access_init.sv
// Register-access initiator: one host request -> command (+ data) bytes, optional read response.
//
//  state     | meaning
//  ----------+-------------------------------------------------------
//  IDLE      | ready for a host request
//  SEND_CMD  | presenting {wr, addr} on the link until accepted
//  SEND_DATA | presenting write data until accepted
//  WAIT_RESP | waiting for the read data byte, bounded by TIMEOUT
//  DONE      | one-cycle response pulse to the host
module reg_access_init #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    reg_access_init_if.slave   bus,
    output logic               busy
);
    import reg_link_pkg::*;

    localparam logic [2:0] S_IDLE      = IDLE;
    localparam logic [2:0] S_SEND_CMD  = SEND_CMD;
    localparam logic [2:0] S_SEND_DATA = SEND_DATA;
    localparam logic [2:0] S_WAIT_RESP = WAIT_RESP;
    localparam logic [2:0] S_DONE      = DONE;

    logic [2:0]        state;
    logic              wr_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_tc;

    // The timer starts from zero on the same edge the read command is accepted.
    assign tmr_clr = (state == S_SEND_CMD) && bus.tx_ready && !wr_reg;
    assign tmr_en  = (state == S_WAIT_RESP);

    resp_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (tmr_tc)
    );

    // Transaction sequencing and request/response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        wr_reg    <= bus.req_wr;
                        addr_reg  <= bus.req_addr;
                        wdata_reg <= bus.req_wdata;
                        state     <= S_SEND_CMD;
                    end
                end
                S_SEND_CMD: begin
                    if (bus.tx_ready) begin
                        state <= wr_reg ? S_SEND_DATA : S_WAIT_RESP;
                    end
                end
                S_SEND_DATA: begin
                    if (bus.tx_ready) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_WAIT_RESP: begin
                    // A response arriving on the terminal cycle still counts as data.
                    if (bus.rx_valid) begin
                        rdata_reg <= bus.rx_data;
                        err_reg   <= 1'b0;
                        state     <= S_DONE;
                    end else if (tmr_tc) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE);
    assign bus.tx_valid  = (state == S_SEND_CMD) || (state == S_SEND_DATA);
    assign bus.tx_data   = (state == S_SEND_CMD)  ? cmd_byte(wr_reg, addr_reg) :
                           (state == S_SEND_DATA) ? wdata_reg : 8'h00;
    assign bus.rsp_valid = (state == S_DONE);
    assign bus.rsp_rdata = rdata_reg;
    assign bus.rsp_err   = err_reg;
    assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_reg_access_init.sv
// Directed self-checking bench for reg_access_init (TIMEOUT = 8).
module tb_reg_access_init;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;
    int   hs0;

    reg_access_init_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    reg_access_init #(.ADDR_W(7), .DATA_W(8), .TIMEOUT(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.tx_valid && bus.tx_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [6:0] addr, input logic [7:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.tx_ready  = 1'b1;
        bus.rx_data   = '0;
        bus.rx_valid  = 1'b0;
        tick();
        tick();

        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_tx_valid",  32'(bus.tx_valid),  32'd0);
        chk("rst_tx_data",   32'(bus.tx_data),   32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        rst = 1'b0;
        tick();

        // Write, no backpressure
        request(1'b1, 7'h15, 8'hA5);
        tick();
        bus.req_valid = 1'b0;
        chk("wr_cmd_valid", 32'(bus.tx_valid),  32'd1);
        chk("wr_cmd_byte",  32'(bus.tx_data),   32'h95);
        chk("wr_cmd_ready", 32'(bus.req_ready), 32'd0);
        tick();
        chk("wr_data_byte", 32'(bus.tx_data),   32'hA5);
        chk("wr_data_rsp",  32'(bus.rsp_valid), 32'd0);
        tick();
        chk("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("wr_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("wr_rsp_err",   32'(bus.rsp_err),   32'd0);
        tick();
        chk("wr_rsp_pulse", 32'(bus.rsp_valid), 32'd0);
        chk("wr_idle_rdy",  32'(bus.req_ready), 32'd1);

        // Read with response
        request(1'b0, 7'h03, 8'hFF);
        tick();
        bus.req_valid = 1'b0;
        chk("rd_cmd_byte", 32'(bus.tx_data), 32'h03);
        tick();
        chk("rd_wait_txv",  32'(bus.tx_valid), 32'd0);
        chk("rd_wait_busy", 32'(busy),         32'd1);
        tick();
        tick();
        chk("rd_wait_norsp", 32'(bus.rsp_valid), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h5C;
        tick();
        bus.rx_valid = 1'b0;
        chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_rsp_rdata", 32'(bus.rsp_rdata), 32'h5C);
        chk("rd_rsp_err",   32'(bus.rsp_err),   32'd0);
        tick();
        chk("rd_hold_rdata", 32'(bus.rsp_rdata), 32'h5C);
        chk("rd_hold_valid", 32'(bus.rsp_valid), 32'd0);

        // Read timeout: 8 cycles after entering WAIT_RESP
        request(1'b0, 7'h7F, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        chk("to_cmd_byte", 32'(bus.tx_data), 32'h7F);
        tick();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("to_wait_%0d", i), 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        chk("to_wait_last", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("to_rsp_err",   32'(bus.rsp_err),   32'd1);
        chk("to_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        tick();

        // Read with data arriving on the terminal cycle
        request(1'b0, 7'h40, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        chk("tc_cmd_byte", 32'(bus.tx_data), 32'h40);
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("tc_wait_norsp", 32'(bus.rsp_valid), 32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h3C;
        tick();
        bus.rx_valid = 1'b0;
        chk("tc_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("tc_rsp_err",   32'(bus.rsp_err),   32'd0);
        chk("tc_rsp_rdata", 32'(bus.rsp_rdata), 32'h3C);
        tick();

        // Backpressure on both bytes of a write
        bus.tx_ready = 1'b0;
        hs0 = hs_cnt;
        request(1'b1, 7'h2A, 8'hC3);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_cmd_valid_%0d", i), 32'(bus.tx_valid),  32'd1);
            chk($sformatf("bp_cmd_byte_%0d", i),  32'(bus.tx_data),   32'hAA);
            chk($sformatf("bp_cmd_ready_%0d", i), 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_data_valid_%0d", i), 32'(bus.tx_valid),  32'd1);
            chk($sformatf("bp_data_byte_%0d", i),  32'(bus.tx_data),   32'hC3);
            chk($sformatf("bp_data_rsp_%0d", i),   32'(bus.rsp_valid), 32'd0);
            tick();
        end
        bus.tx_ready = 1'b1;
        tick();
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_handshakes", 32'(hs_cnt - hs0), 32'd2);
        tick();

        // Reset during WAIT_RESP
        request(1'b0, 7'h05, 8'h00);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("rs_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_busy",      32'(busy),          32'd0);
        chk("rs_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rs_tx_valid",  32'(bus.tx_valid),  32'd0);
        chk("rs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rs_no_rsp_%0d", i), 32'(bus.rsp_valid), 32'd0);
        end

        // Stray rx strobe in IDLE
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hEE;
        tick();
        bus.rx_valid = 1'b0;
        chk("stray_busy",  32'(busy),          32'd0);
        chk("stray_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("stray_rsp",   32'(bus.rsp_valid), 32'd0);

        // Fresh write after reset
        request(1'b1, 7'h01, 8'h77);
        tick();
        bus.req_valid = 1'b0;
        chk("post_cmd_byte", 32'(bus.tx_data), 32'h81);
        tick();
        chk("post_data_byte", 32'(bus.tx_data), 32'h77);
        tick();
        chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("post_rsp_err",   32'(bus.rsp_err),   32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
